// File: rtl/ahb_pkg.sv
// AHB-Lite bus constants and the pipeline slot record shared by the command master.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // One command's bookkeeping while it sits in the address or data phase.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [1:0] size;
    logic [1:0] addr_lo;
    logic       cancelled;
    logic       misaligned;
  } slot_t;

  // Size code 3 has no wider transfer behind it, so it is handled as a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: replicates write data across lanes and extracts/zero-extends read data.
// Latency: purely combinational.
// Backpressure: none; follows whatever slot drives it.
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] wr_lanes_o,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_addr_lo_i,
  input  logic [31:0] rd_lanes_i,
  output logic [31:0] rd_data_o
);

  // Replicate narrow write data so the slave finds it on whichever lane the address selects.
  always_comb begin
    wr_lanes_o = wr_data_i;
    case ({1'b0, wr_size_i})
      HSIZE_BYTE: wr_lanes_o = {4{wr_data_i[7:0]}};
      HSIZE_HALF: wr_lanes_o = {2{wr_data_i[15:0]}};
      HSIZE_WORD: wr_lanes_o = wr_data_i;
      default:    wr_lanes_o = wr_data_i;
    endcase
  end

  // Pull the addressed lane down to bit 0 and clear everything above it.
  always_comb begin
    rd_data_o = rd_lanes_i;
    case ({1'b0, rd_size_i})
      HSIZE_BYTE: rd_data_o = {24'd0, rd_lanes_i[{rd_addr_lo_i, 3'b000} +: 8]};
      HSIZE_HALF: rd_data_o = {16'd0, (rd_addr_lo_i[1] ? rd_lanes_i[31:16] : rd_lanes_i[15:0])};
      HSIZE_WORD: rd_data_o = rd_lanes_i;
      default:    rd_data_o = rd_lanes_i;
    endcase
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-master AHB-Lite initiator: valid/ready commands in, SINGLE transfers out, one in-order response each.
// Latency: accept at edge k -> NONSEQ cycle k+1 -> data phase k+2 -> rsp_valid k+3; one command per cycle sustained.
// Backpressure: cmd_ready = HREADY && !err_first; optional misalignment trap under AHB_MASTER_ALIGN_CHECK_EN.
module ahb_cmd_master
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // Address-phase registers (what the bus sees now) plus the write data waiting for its data phase.
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] wdata_q, wdata_d;
  slot_t       ap_q, ap_d;

  // Data-phase slot and the lane-steered write data driven during it.
  slot_t       dp_q, dp_d;
  logic [31:0] hwdata_q, hwdata_d;

  // Set by the first cycle of an ERROR response; blocks new commands until the error fallout drains.
  logic        err_q, err_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]  cmd_size_n;
  logic        cmd_mis;
  logic        accept;
  logic        dp_done;
  logic [31:0] wr_lanes;
  logic [31:0] rd_data;

  assign cmd_ready  = HREADY && !err_q;
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_size_n = norm_size(cmd_size);
  assign dp_done    = HREADY && dp_q.valid;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
  assign cmd_mis = is_misaligned(cmd_size_n, cmd_addr[1:0]);
`else
  assign cmd_mis = 1'b0;
`endif

  ahb_lane_align u_lane_align (
    .wr_size_i    (ap_q.size),
    .wr_data_i    (wdata_q),
    .wr_lanes_o   (wr_lanes),
    .rd_size_i    (dp_q.size),
    .rd_addr_lo_i (dp_q.addr_lo),
    .rd_lanes_i   (HRDATA),
    .rd_data_o    (rd_data)
  );

  // Address phase: load on HREADY, otherwise hold, except that an error's first cycle kills the pending NONSEQ.
  always_comb begin
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    wdata_d  = wdata_q;
    ap_d     = ap_q;
    if (HREADY) begin
      if (accept) begin
        haddr_d         = cmd_addr;
        hwrite_d        = cmd_write;
        hsize_d         = {1'b0, cmd_size_n};
        wdata_d         = cmd_wdata;
        // A trapped misaligned command still owns the slot so its response stays in order.
        htrans_d        = cmd_mis ? HTRANS_IDLE : HTRANS_NONSEQ;
        ap_d.valid      = 1'b1;
        ap_d.write      = cmd_write;
        ap_d.size       = cmd_size_n;
        ap_d.addr_lo    = cmd_addr[1:0];
        ap_d.cancelled  = 1'b0;
        ap_d.misaligned = cmd_mis;
      end else begin
        htrans_d = HTRANS_IDLE;
        ap_d     = '0;
      end
    end else if (HRESP && dp_q.valid && ap_q.valid) begin
      htrans_d       = HTRANS_IDLE;
      ap_d.cancelled = 1'b1;
    end
  end

  // Data phase: every occupied address slot advances on HREADY; HWDATA only changes for real writes.
  always_comb begin
    dp_d     = dp_q;
    hwdata_d = hwdata_q;
    if (HREADY) begin
      dp_d = ap_q;
      if (htrans_q == HTRANS_NONSEQ && hwrite_q) begin
        hwdata_d = wr_lanes;
      end
    end
  end

  // Response: one registered pulse per completed slot; error data is forced to zero.
  always_comb begin
    rsp_valid_d = dp_done;
    rsp_error_d = dp_done && (HRESP || dp_q.cancelled || dp_q.misaligned);
    rsp_rdata_d = 32'd0;
    if (dp_done && !dp_q.write && !rsp_error_d) begin
      rsp_rdata_d = rd_data;
    end
  end

  // Error hold: set on HRESP with HREADY low, released once no cancelled command is left behind it.
  always_comb begin
    err_d = err_q;
    if (!HREADY && HRESP && dp_q.valid) begin
      err_d = 1'b1;
    end else if (HREADY && err_q && !ap_q.valid) begin
      err_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight commands without a response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q     <= 32'd0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      wdata_q     <= 32'd0;
      ap_q        <= '0;
      dp_q        <= '0;
      hwdata_q    <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      wdata_q     <= wdata_d;
      ap_q        <= ap_d;
      dp_q        <= dp_d;
      hwdata_q    <= hwdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master with a small AHB-Lite memory slave.
// Latency: checks are placed at the exact cycle each output is due.
// Backpressure: HREADY/HRESP are driven directly by the directed steps.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_cnt = 0;

  // Slave memory model: 16 words, byte-lane writes, read data from the data-phase address.
  logic [31:0] mem [16];
  logic        s_vld, s_wr;
  logic [31:0] s_addr;
  logic [2:0]  s_size;
  logic        rd_ovr;
  logic [31:0] rd_ovr_val;

  assign HRDATA = rd_ovr ? rd_ovr_val : mem[s_addr[5:2]];

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Count every response pulse to catch drops and duplicates.
  always @(posedge HCLK) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // Slave: capture NONSEQ address phases, commit write data when the data phase completes.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_vld <= 1'b0; s_wr <= 1'b0; s_addr <= 32'd0; s_size <= 3'd0;
    end else if (HREADY) begin
      if (s_vld && s_wr && !HRESP) begin
        for (int i = 0; i < 4; i++) begin
          if ((s_size == 3'd0) ? (i == int'(s_addr[1:0])) :
              (s_size == 3'd1) ? ((i / 2) == int'(s_addr[1])) : 1'b1)
            mem[s_addr[5:2]][8*i +: 8] = HWDATA[8*i +: 8];
        end
      end
      s_vld  <= (HTRANS == 2'b10);
      s_addr <= HADDR;
      s_wr   <= HWRITE;
      s_size <= HSIZE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = s; cmd_wdata = d;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_size = 0; cmd_wdata = 0;
    HREADY = 1; HRESP = 0; rd_ovr = 0; rd_ovr_val = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[1] = 32'hCAFEF00D;

    // Reset values
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_htrans", HTRANS, 0);   chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);   chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);   chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_rsp_error", rsp_error, 0);
    chk("const_hburst", HBURST, 0); chk("const_hprot", HPROT, 4'b0011);
    chk("const_hmastlock", HMASTLOCK, 0);
    tick(); tick();
    HRESETn = 1'b1; #1;
    chk("rdy_follows_hready1", cmd_ready, 1);
    HREADY = 0; #1;
    chk("rdy_follows_hready0", cmd_ready, 0);
    HREADY = 1; #1;

    // Word write then read, zero wait states
    send(32'h100, 1, 2, 32'hDEADBEEF); tick();
    chk("t1_htrans_wr", HTRANS, 2'b10); chk("t1_haddr_wr", HADDR, 32'h100);
    chk("t1_hwrite_wr", HWRITE, 1);     chk("t1_hsize_wr", HSIZE, 2);
    send(32'h100, 0, 2, 32'd0); tick();
    chk("t1_htrans_rd", HTRANS, 2'b10); chk("t1_hwrite_rd", HWRITE, 0);
    chk("t1_hwdata", HWDATA, 32'hDEADBEEF); chk("t1_no_rsp_k2", rsp_valid, 0);
    idle(); tick();
    chk("t1_rsp_wr_k3", rsp_valid, 1); chk("t1_rsp_wr_err", rsp_error, 0);
    chk("t1_rsp_wr_data", rsp_rdata, 0); chk("t1_htrans_idle", HTRANS, 0);
    tick();
    chk("t1_rsp_rd_k4", rsp_valid, 1); chk("t1_rsp_rd_data", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_rsp_end", rsp_valid, 0); chk("t1_rsp_cnt", rsp_cnt, 2);

    // Byte write lanes, then half and byte reads from a fixed HRDATA pattern
    send(32'h103, 1, 0, 32'h0000005A); tick();
    chk("t2_hsize_b", HSIZE, 0); chk("t2_haddr_b", HADDR, 32'h103);
    idle(); tick();
    chk("t2_hwdata_b", HWDATA, 32'h5A5A5A5A);
    tick();
    chk("t2_rsp_bw", rsp_valid, 1);
    send(32'h102, 0, 1, 32'd0); tick();
    send(32'h101, 0, 0, 32'd0); tick();
    idle(); rd_ovr = 1; rd_ovr_val = 32'h12345678; tick();
    chk("t2_half_vld", rsp_valid, 1); chk("t2_half_data", rsp_rdata, 32'h00001234);
    tick();
    chk("t2_byte_vld", rsp_valid, 1); chk("t2_byte_data", rsp_rdata, 32'h00000056);
    rd_ovr = 0; tick();
    chk("t2_rsp_cnt", rsp_cnt, 5);

    // Two wait states on a read data phase with a write waiting in the address phase
    send(32'h100, 0, 2, 32'd0); tick();
    send(32'h108, 1, 2, 32'h11223344); tick();
    idle(); HREADY = 0; #1;
    chk("t3_rdy_low", cmd_ready, 0); chk("t3_htrans_w1", HTRANS, 2'b10);
    chk("t3_haddr_w1", HADDR, 32'h108);
    tick();
    chk("t3_haddr_w2", HADDR, 32'h108); chk("t3_htrans_w2", HTRANS, 2'b10);
    chk("t3_hwrite_w2", HWRITE, 1); chk("t3_hwdata_hold", HWDATA, 32'h5A5A5A5A);
    chk("t3_no_rsp_w2", rsp_valid, 0);
    tick();
    HREADY = 1;
    chk("t3_no_rsp_w3", rsp_valid, 0);
    tick();
    chk("t3_rsp_late", rsp_valid, 1); chk("t3_rsp_data", rsp_rdata, 32'h5AADBEEF);
    chk("t3_hwdata", HWDATA, 32'h11223344);
    tick();
    chk("t3_rsp_wr", rsp_valid, 1);
    tick();
    chk("t3_rsp_cnt", rsp_cnt, 7);

    // Two-cycle ERROR response with a write pending behind it
    send(32'h4000, 0, 2, 32'd0); tick();
    send(32'h104, 1, 2, 32'hBAD0BAD0); tick();
    idle(); HRESP = 1; HREADY = 0; #1;
    chk("t4_rdy_e1", cmd_ready, 0); chk("t4_htrans_e1", HTRANS, 2'b10);
    tick();
    chk("t4_htrans_cancel", HTRANS, 0);
    HREADY = 1; #1;
    chk("t4_rdy_e2", cmd_ready, 0);
    tick();
    HRESP = 0;
    chk("t4_rsp1_vld", rsp_valid, 1); chk("t4_rsp1_err", rsp_error, 1);
    chk("t4_rsp1_data", rsp_rdata, 0); chk("t4_rdy_hold", cmd_ready, 0);
    tick();
    chk("t4_rsp2_vld", rsp_valid, 1); chk("t4_rsp2_err", rsp_error, 1);
    chk("t4_rdy_back", cmd_ready, 1);
    tick();
    chk("t4_rsp_end", rsp_valid, 0); chk("t4_rsp_cnt", rsp_cnt, 9);
    chk("t4_mem104", mem[1], 32'hCAFEF00D);

    // Asynchronous reset in the middle of a write data phase
    send(32'h10C, 1, 2, 32'h00000077); tick();
    idle(); tick();
    chk("t5_hwdata_pre", HWDATA, 32'h00000077);
    #2 HRESETn = 1'b0; #1;
    chk("t5_htrans", HTRANS, 0); chk("t5_haddr", HADDR, 0);
    chk("t5_hwdata", HWDATA, 0); chk("t5_hwrite", HWRITE, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    @(posedge HCLK); #2 HRESETn = 1'b1;
    tick(); tick(); tick();
    chk("t5_rsp_cnt", rsp_cnt, 9); chk("t5_mem10c", mem[3], 0);

    // Misaligned word read behind an aligned read (size code 3 acts as word)
    send(32'h100, 0, 3, 32'd0); tick();
    chk("t6_hsize_norm", HSIZE, 2);
    send(32'h102, 0, 2, 32'd0); tick();
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    chk("t6_htrans_mis", HTRANS, 0);
`else
    chk("t6_htrans_mis", HTRANS, 2'b10); chk("t6_haddr_mis", HADDR, 32'h102);
`endif
    idle(); tick();
    chk("t6_rsp1_vld", rsp_valid, 1); chk("t6_rsp1_err", rsp_error, 0);
    chk("t6_rsp1_data", rsp_rdata, 32'h5AADBEEF);
    tick();
    chk("t6_rsp2_vld", rsp_valid, 1);
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    chk("t6_rsp2_err", rsp_error, 1); chk("t6_rsp2_data", rsp_rdata, 0);
`else
    chk("t6_rsp2_err", rsp_error, 0); chk("t6_rsp2_data", rsp_rdata, 32'h5AADBEEF);
`endif
    tick();
    chk("t6_rsp_cnt", rsp_cnt, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

Single-master AHB-Lite initiator that converts a simple valid/ready command stream into single (HBURST=SINGLE) AHB-Lite transfers and returns one in-order response per command. Pipelined: one command in the address phase while the previous one completes its data phase. Sits between on-chip agents (loader, debug bridge, DMA front-end) and the AHB-Lite interconnect that feeds the RAM and peripheral slaves.

## Interface
Parameters:
- none; all bus constants come from `ahb_pkg`.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted at a rising edge where cmd_valid && cmd_ready.
- cmd_addr  in  32  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle pulse per completed command, in command order.
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes and errors.
- rsp_error  out  1  qualifies rsp_valid; 1 = HRESP error or cancelled transfer.
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HMASTLOCK  out  1; HWDATA  out  32.
- HRDATA  in  32; HREADY  in  1; HRESP  in  1.

## Operation
- Address-phase registers: HADDR, HTRANS, HWRITE, HSIZE. They load only at an edge with HREADY=1.
- cmd_ready = HREADY && !err_first. This is combinational from HREADY.
- Accepted command: drives HTRANS=NONSEQ on the next cycle. With HREADY=1 and no accept, HTRANS=IDLE.
- Constant outputs: HBURST=SINGLE (000), HPROT=4'b0011, HMASTLOCK=0.
- Data-phase entry: at an edge where HREADY=1 and HTRANS=NONSEQ, the address-phase info moves into the data-phase slot (dp_valid, write, size, addr[1:0]).
- Write data lanes: HWDATA is driven from the data-phase slot.
  - byte: replicated to all 4 lanes.
  - halfword: replicated to both halves.
  - word: passed as-is.
- Data-phase completion (HREADY=1 with dp_valid):
  - Next cycle: rsp_valid=1.
  - Reads: rsp_rdata = HRDATA lane selected by addr[1:0]/size, shifted to bit 0 and zero-extended.
  - rsp_error = HRESP.
- Two-cycle error response:
  - Cycle 1 (HRESP=1, HREADY=0): set err_first. At that edge, a pending NONSEQ is replaced by IDLE and its command marked cancelled.
  - Cycle 2 (HRESP=1, HREADY=1): the failed transfer responds with rsp_error=1.
  - The cancelled command responds with rsp_error=1 on the following cycle.
  - cmd_ready stays low until both responses have been issued.
- Wait states: while HREADY=0, all address-phase outputs and HWDATA hold stable.
- Reset, including mid-transfer: all state clears immediately. In-flight commands produce no response.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0. cmd_ready follows HREADY once reset is released.
- Latency at zero wait states: accept at edge k → NONSEQ in cycle k+1 → data phase k+2 → rsp_valid in cycle k+3.
- Throughput: one command per cycle sustained. Each wait state adds one cycle.
- Ordering: responses are strictly in acceptance order; no response is dropped or duplicated.

## Configuration
- `AHB_MASTER_ALIGN_CHECK_EN` defined:
  - A misaligned command is accepted but not issued on the bus. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - Its address-phase slot drives HTRANS=IDLE.
  - It responds in order with rsp_error=1, in the cycle it would have responded had it been issued.
- `AHB_MASTER_ALIGN_CHECK_EN` undefined: misaligned commands are issued unchanged. Slave behaviour is then undefined.

## Structure
- `ahb_pkg` holds:
  - HTRANS_IDLE/NONSEQ.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_SINGLE.
  - HPROT_DEFAULT.
  - A data-phase slot struct (valid, write, size, addr_lo, cancelled, misaligned).
- Sub-module `ahb_lane_align` (combinational): write-lane replication and read-lane extraction/zero-extension from size and addr[1:0].

## Test plan
- Word write then read, zero wait: write 0x100 ← 0xDEADBEEF, then read 0x100. HTRANS=NONSEQ on consecutive cycles; rsp_valid at k+3 and k+4; rsp_rdata = 0xDEADBEEF.
- Byte/half lanes:
  - Byte write 0x103 ← 0x5A gives HWDATA = 0x5A5A5A5A.
  - Half read 0x102 with HRDATA = 0x12345678 gives rsp_rdata = 0x00001234.
- Wait states: slave holds HREADY=0 for 2 cycles during a read data phase. HADDR/HTRANS of the next command stay stable, cmd_ready=0, and the response is delayed by exactly 2 cycles.
- Error with pipelined command: read 0x4000 gets the HRESP error pattern while a write to 0x104 is pending.
  - Pending HTRANS becomes IDLE.
  - Two responses follow in order, both with rsp_error=1.
  - Memory at 0x104 is unchanged.
- Async reset asserted during a data phase: all outputs go to their reset values immediately, and no rsp_valid appears after release.
- With `AHB_MASTER_ALIGN_CHECK_EN`: word read at 0x102 leaves HTRANS=IDLE in its slot and produces rsp_valid with rsp_error=1, in order behind a preceding valid read.
